// File: rtl/core_bus_arbiter_pkg.sv
// Shared types for the I/D to cache-bus arbiter.
package core_bus_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;

  localparam logic [1:0] MSIZE_WORD = 2'b10;

  // Request fields captured at grant time and replayed onto the cache bus.
  typedef struct packed {
    logic        is_write;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } creq_t;

endpackage

// File: rtl/core_bus_arbiter_if.sv
// Instruction, data and downstream cache-bus signals of the arbiter.
interface core_bus_arbiter_if;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;

  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dreq_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;

  logic        creq_valid;
  logic        creq_is_write;
  logic [31:0] creq_addr;
  logic [1:0]  creq_size;
  logic [3:0]  creq_strobe;
  logic [31:0] creq_data;
  logic        cresp_ready;
  logic        cresp_last;
  logic [31:0] cresp_data;

  // Arbiter side.
  modport slave (
    input  ireq_valid, ireq_addr,
    output ireq_addr_ok, iresp_data_ok, iresp_data,
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dreq_addr_ok, dresp_data_ok, dresp_data,
    output creq_valid, creq_is_write, creq_addr, creq_size, creq_strobe, creq_data,
    input  cresp_ready, cresp_last, cresp_data
  );

  // Core/cache side.
  modport master (
    output ireq_valid, ireq_addr,
    input  ireq_addr_ok, iresp_data_ok, iresp_data,
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dreq_addr_ok, dresp_data_ok, dresp_data,
    input  creq_valid, creq_is_write, creq_addr, creq_size, creq_strobe, creq_data,
    output cresp_ready, cresp_last, cresp_data
  );
endinterface

// File: rtl/core_bus_grant.sv
// Combinational grant decision. ARB_ROUND_ROBIN_EN selects round-robin
// tie-break; otherwise D has priority unless I is starving.
module core_bus_grant
  import core_bus_arbiter_pkg::*;
(
  input  logic   ivalid_i,
  input  logic   dvalid_i,
  input  grant_t last_grant_i,
  input  logic   starve_i,
  output grant_t grant_o,
  output logic   grant_vld_o
);

`ifdef ARB_ROUND_ROBIN_EN
  logic unused_starve;
  assign unused_starve = starve_i;
`endif

  always_comb begin
    grant_vld_o = ivalid_i | dvalid_i;
    grant_o     = GRANT_I;
    if (ivalid_i && dvalid_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_o = (last_grant_i == GRANT_I) ? GRANT_D : GRANT_I;
`else
      grant_o = starve_i ? GRANT_I : GRANT_D;
`endif
    end else if (dvalid_i) begin
      grant_o = GRANT_D;
    end
  end

`ifndef ARB_ROUND_ROBIN_EN
  logic unused_last;
  assign unused_last = last_grant_i;
`endif

endmodule

// File: rtl/core_bus_arbiter.sv
// Arbitrates I and D requests onto one cache bus, one transaction at a time.
// Optional ARB_ROUND_ROBIN_EN replaces fixed priority with round-robin.
module core_bus_arbiter
  import core_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  core_bus_arbiter_if.slave bus
);

  arb_state_t  state_q, state_d;
  creq_t       lat_q, lat_d;
  grant_t      last_grant_q, last_grant_d;
  logic [31:0] irdata_q, irdata_d, drdata_q, drdata_d;
  logic        iok_q, iok_d, dok_q, dok_d;
  grant_t      gnt;
  logic        gnt_vld, starve, done, take;

  core_bus_grant u_grant (
    .ivalid_i     (bus.ireq_valid),
    .dvalid_i     (bus.dreq_valid),
    .last_grant_i (last_grant_q),
    .starve_i     (starve),
    .grant_o      (gnt),
    .grant_vld_o  (gnt_vld)
  );

  assign done = bus.cresp_ready & bus.cresp_last;
  assign take = (state_q == IDLE) && gnt_vld;

`ifndef ARB_ROUND_ROBIN_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_q, starve_d;

  assign starve = (starve_q == CW'(STARVE_LIMIT));

  // Counts only D grants that made a waiting I request lose.
  always_comb begin
    starve_d = starve_q;
    if (take) begin
      if (gnt == GRANT_I)                   starve_d = '0;
      else if (bus.ireq_valid && !starve)   starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  assign starve = 1'b0;
`endif

  always_comb begin
    state_d           = state_q;
    lat_d             = lat_q;
    last_grant_d      = last_grant_q;
    irdata_d          = irdata_q;
    drdata_d          = drdata_q;
    iok_d             = 1'b0;
    dok_d             = 1'b0;
    bus.ireq_addr_ok  = 1'b0;
    bus.dreq_addr_ok  = 1'b0;
    bus.creq_valid    = 1'b0;
    bus.creq_is_write = 1'b0;
    bus.creq_addr     = '0;
    bus.creq_size     = '0;
    bus.creq_strobe   = '0;
    bus.creq_data     = '0;

    if (state_q != IDLE) begin
      bus.creq_valid    = 1'b1;
      bus.creq_is_write = lat_q.is_write;
      bus.creq_addr     = lat_q.addr;
      bus.creq_size     = lat_q.size;
      bus.creq_strobe   = lat_q.strobe;
      bus.creq_data     = lat_q.data;
    end

    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          last_grant_d = gnt;
          if (gnt == GRANT_I) begin
            bus.ireq_addr_ok = ~reset;
            lat_d.is_write   = 1'b0;
            lat_d.addr       = bus.ireq_addr;
            lat_d.size       = MSIZE_WORD;
            lat_d.strobe     = 4'h0;
            lat_d.data       = 32'h0;
            state_d          = BUSY_I;
          end else begin
            bus.dreq_addr_ok = ~reset;
            lat_d.is_write   = |bus.dreq_strobe;
            lat_d.addr       = bus.dreq_addr;
            lat_d.size       = bus.dreq_size;
            lat_d.strobe     = bus.dreq_strobe;
            lat_d.data       = bus.dreq_data;
            state_d          = BUSY_D;
          end
        end
      end
      BUSY_I: if (done) begin
        irdata_d = bus.cresp_data;
        iok_d    = 1'b1;
        state_d  = IDLE;
      end
      BUSY_D: if (done) begin
        drdata_d = bus.cresp_data;
        dok_d    = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      lat_q        <= '0;
      last_grant_q <= GRANT_I;
      irdata_q     <= '0;
      drdata_q     <= '0;
      iok_q        <= 1'b0;
      dok_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      last_grant_q <= last_grant_d;
      irdata_q     <= irdata_d;
      drdata_q     <= drdata_d;
      iok_q        <= iok_d;
      dok_q        <= dok_d;
    end
  end

  assign bus.iresp_data_ok = iok_q;
  assign bus.iresp_data    = irdata_q;
  assign bus.dresp_data_ok = dok_q;
  assign bus.dresp_data    = drdata_q;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter; expectations follow ARB_ROUND_ROBIN_EN.
module tb_core_bus_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_i;

  core_bus_arbiter_if bus();

  core_bus_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.ireq_valid = 1'b1; bus.ireq_addr = 32'h0;
    bus.dreq_valid = 1'b0; bus.dreq_addr = 32'h0; bus.dreq_size = 2'b10;
    bus.dreq_strobe = 4'h0; bus.dreq_data = 32'h0;
    bus.cresp_ready = 1'b0; bus.cresp_last = 1'b0; bus.cresp_data = 32'h0;
    tick(); tick(); #2;
    chk("rst_iaddr_ok", bus.ireq_addr_ok, 0);
    chk("rst_creq_valid", bus.creq_valid, 0);
    chk("rst_idata_ok", bus.iresp_data_ok, 0);
    chk("rst_iresp_data", bus.iresp_data, 0);
    chk("rst_creq_addr", bus.creq_addr, 0);

    // I-only read, last on the 3rd bus cycle.
    tick(); reset = 1'b0; bus.ireq_valid = 1'b0;
    tick(); bus.ireq_valid = 1'b1; bus.ireq_addr = 32'hBFC0_0000; #2;
    chk("i_addr_ok", bus.ireq_addr_ok, 1);
    chk("i_d_addr_ok", bus.dreq_addr_ok, 0);
    chk("i_idle_creq_valid", bus.creq_valid, 0);
    tick(); bus.ireq_valid = 1'b0; #2;
    chk("i_creq_valid", bus.creq_valid, 1);
    chk("i_creq_addr", bus.creq_addr, 32'hBFC0_0000);
    chk("i_creq_wr", bus.creq_is_write, 0);
    chk("i_creq_size", bus.creq_size, 2'b10);
    chk("i_creq_strobe", bus.creq_strobe, 0);
    tick(); #2;
    tick(); bus.cresp_ready = 1'b1; bus.cresp_last = 1'b1; bus.cresp_data = 32'h1234_5678; #2;
    chk("i_ok_early", bus.iresp_data_ok, 0);
    tick(); bus.cresp_ready = 1'b0; bus.cresp_last = 1'b0; #2;
    chk("i_data_ok", bus.iresp_data_ok, 1);
    chk("i_resp_data", bus.iresp_data, 32'h1234_5678);
    chk("i_done_creq_valid", bus.creq_valid, 0);
    tick(); #2;
    chk("i_ok_one_cycle", bus.iresp_data_ok, 0);
    chk("i_data_hold", bus.iresp_data, 32'h1234_5678);

    // Both valid: D write first, I on the next IDLE.
    tick();
    bus.dreq_valid = 1'b1; bus.dreq_addr = 32'h8000_0010; bus.dreq_strobe = 4'hF;
    bus.dreq_data = 32'hDEAD_BEEF; bus.dreq_size = 2'b10;
    bus.ireq_valid = 1'b1; bus.ireq_addr = 32'hBFC0_0004; #2;
    chk("both_d_ok", bus.dreq_addr_ok, 1);
    chk("both_i_not_ok", bus.ireq_addr_ok, 0);
    tick(); bus.dreq_valid = 1'b0; #2;
    chk("dw_is_write", bus.creq_is_write, 1);
    chk("dw_addr", bus.creq_addr, 32'h8000_0010);
    chk("dw_data", bus.creq_data, 32'hDEAD_BEEF);
    chk("dw_strobe", bus.creq_strobe, 4'hF);
    chk("busy_no_i_ok", bus.ireq_addr_ok, 0);
    tick(); bus.cresp_ready = 1'b1; bus.cresp_last = 1'b1; bus.cresp_data = 32'h0; #2;
    tick(); bus.cresp_ready = 1'b0; bus.cresp_last = 1'b0; #2;
    chk("dw_data_ok", bus.dresp_data_ok, 1);
    chk("b2b_i_ok", bus.ireq_addr_ok, 1);
    chk("b2b_d_not_ok", bus.dreq_addr_ok, 0);
    tick(); bus.ireq_valid = 1'b0; #2;
    chk("i2_addr", bus.creq_addr, 32'hBFC0_0004);
    chk("i2_wr", bus.creq_is_write, 0);
    chk("dw_ok_one_cycle", bus.dresp_data_ok, 0);

    // Multi-beat: ready for 4 cycles, last only on the 4th.
    for (int b = 1; b <= 4; b++) begin
      tick(); bus.cresp_ready = 1'b1; bus.cresp_last = (b == 4);
      bus.cresp_data = 32'hA000_0000 + b; #2;
      chk("mb_still_busy", bus.creq_valid, 1);
      chk("mb_no_ok", bus.iresp_data_ok, 0);
    end
    tick(); bus.cresp_ready = 1'b0; bus.cresp_last = 1'b0; #2;
    chk("mb_data_ok", bus.iresp_data_ok, 1);
    chk("mb_data", bus.iresp_data, 32'hA000_0004);
    tick(); #2;
    chk("mb_single_ok", bus.iresp_data_ok, 0);

    // Both held valid: starvation relief or round-robin alternation.
    bus.dreq_strobe = 4'h0; bus.dreq_addr = 32'h8000_0100; bus.ireq_addr = 32'hBFC0_0100;
    bus.cresp_data = 32'h5555_0000;
    for (int k = 0; k < 10; k++) begin
      tick(); bus.ireq_valid = 1'b1; bus.dreq_valid = 1'b1;
      bus.cresp_ready = 1'b0; bus.cresp_last = 1'b0; #2;
`ifdef ARB_ROUND_ROBIN_EN
      exp_i = (k % 2 == 1);
`else
      exp_i = (k == 8);
`endif
      chk($sformatf("grant%0d_i", k), bus.ireq_addr_ok, exp_i);
      chk($sformatf("grant%0d_d", k), bus.dreq_addr_ok, !exp_i);
      tick(); bus.cresp_ready = 1'b1; bus.cresp_last = 1'b1; #2;
    end
    tick(); bus.ireq_valid = 1'b0; bus.dreq_valid = 1'b0;
    bus.cresp_ready = 1'b0; bus.cresp_last = 1'b0; #2;

    // Reset on the 2nd BUSY_D cycle.
    tick(); bus.dreq_valid = 1'b1; bus.dreq_addr = 32'h8000_0020; #2;
    chk("ab_d_ok", bus.dreq_addr_ok, 1);
    tick(); bus.dreq_valid = 1'b0; #2;
    chk("ab_busy1", bus.creq_valid, 1);
    tick(); bus.cresp_ready = 1'b1; bus.cresp_last = 1'b1; bus.cresp_data = 32'h7777_7777;
    #1 reset = 1'b1; #1;
    chk("ab_creq_drop", bus.creq_valid, 0);
    chk("ab_creq_addr", bus.creq_addr, 0);
    chk("ab_dresp_data", bus.dresp_data, 0);
    tick(); reset = 1'b0; bus.cresp_ready = 1'b0; bus.cresp_last = 1'b0; #2;
    chk("ab_no_ok1", bus.dresp_data_ok, 0);
    chk("ab_idle", bus.creq_valid, 0);
    tick(); #2;
    chk("ab_no_ok2", bus.dresp_data_ok, 0);
    tick(); bus.dreq_valid = 1'b1; bus.dreq_addr = 32'h8000_0040; #2;
    chk("post_d_ok", bus.dreq_addr_ok, 1);
    tick(); bus.dreq_valid = 1'b0; bus.cresp_ready = 1'b1; bus.cresp_last = 1'b1;
    bus.cresp_data = 32'hCAFE_F00D; #2;
    chk("post_addr", bus.creq_addr, 32'h8000_0040);
    tick(); bus.cresp_ready = 1'b0; bus.cresp_last = 1'b0; #2;
    chk("post_data_ok", bus.dresp_data_ok, 1);
    chk("post_data", bus.dresp_data, 32'hCAFE_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
